// File: rtl/pulse_peak_pkg.sv
// Shared types, default widths and helpers for the pulse peak detector.
// The width defaults match the DC blocker upstream.
package pulse_peak_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PULSE = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH       = 12;
    localparam int DEFAULT_TIME_WIDTH  = 16;
    localparam int DEFAULT_COUNT_WIDTH = 32;

    // Increment value, holding at the all-ones value of a 'bits'-wide field.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned bits);
        logic [63:0] max_v;
        max_v = (bits >= 32'd64) ? {64{1'b1}} : ((64'd1 << bits) - 64'd1);
        return (value >= max_v) ? max_v : (value + 64'd1);
    endfunction

endpackage

// File: rtl/pulse_peak_detector_sample_strobe.sv
// Rising-edge detector on the sample-rate square wave; s is high for one clk
// per sample.
module sample_strobe (
    input  logic clk,
    input  logic reset,
    input  logic sampl_freq,
    output logic s
);

    logic sampl_freq_d_r;

    // Delayed copy of the sample clock for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sampl_freq_d_r <= 1'b0;
        end else begin
            sampl_freq_d_r <= sampl_freq;
        end
    end

    assign s = sampl_freq & ~sampl_freq_d_r;

endmodule

// File: rtl/pulse_peak_detector.sv
// Hysteresis-triggered pulse finder: reports peak amplitude and trigger-to-peak
// sample count per pulse, then waits a programmable dead time before re-arming.
module pulse_peak_detector
    import pulse_peak_pkg::*;
#(
    parameter int width       = DEFAULT_WIDTH,
    parameter int time_width  = DEFAULT_TIME_WIDTH,
    parameter int count_width = DEFAULT_COUNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sampl_freq,
    input  logic                    enable,
    input  logic signed [width-1:0] data_in,
    input  logic signed [width-1:0] threshold_high,
    input  logic signed [width-1:0] threshold_low,
    input  logic [time_width-1:0]   dead_time,
    output logic signed [width-1:0] peak_value,
    output logic [time_width-1:0]   peak_time,
    output logic                    peak_valid,
    output logic                    busy,
    output logic [count_width-1:0]  event_count
);

    localparam logic [time_width-1:0] TIME_ZERO = {time_width{1'b0}};
    localparam logic [time_width-1:0] TIME_ONE  = {{(time_width-1){1'b0}}, 1'b1};

    logic                    s_s;
    state_t                  state_r, state_s;
    logic signed [width-1:0] peak_reg_r, peak_reg_s;
    logic [time_width-1:0]   rise_cnt_r, rise_cnt_s, rise_inc_s;
    logic [time_width-1:0]   peak_t_r, peak_t_s;
    logic [time_width-1:0]   dead_cnt_r, dead_cnt_s;
    logic [count_width-1:0]  count_inc_s;
    logic                    report_s;

    sample_strobe u_strobe (
        .clk        (clk),
        .reset      (reset),
        .sampl_freq (sampl_freq),
        .s          (s_s)
    );

    // Next-state and pulse bookkeeping; enable low overrides everything.
    always_comb begin
        state_s     = state_r;
        peak_reg_s  = peak_reg_r;
        rise_cnt_s  = rise_cnt_r;
        peak_t_s    = peak_t_r;
        dead_cnt_s  = dead_cnt_r;
        report_s    = 1'b0;
        rise_inc_s  = time_width'(sat_inc(64'(rise_cnt_r), time_width));
        count_inc_s = count_width'(sat_inc(64'(event_count), count_width));
        if (!enable) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = ARMED;
                end
                ARMED: begin
                    if (s_s && (data_in >= threshold_high)) begin
                        state_s    = PULSE;
                        peak_reg_s = data_in;
                        rise_cnt_s = TIME_ZERO;
                        peak_t_s   = TIME_ZERO;
                    end else begin
                        state_s = ARMED;
                    end
                end
                PULSE: begin
                    if (s_s) begin
                        rise_cnt_s = rise_inc_s;
                        // Strictly greater, so ties keep the earliest peak.
                        if (data_in > peak_reg_r) begin
                            peak_reg_s = data_in;
                            peak_t_s   = rise_inc_s;
                        end else begin
                            peak_reg_s = peak_reg_r;
                        end
                        if (data_in < threshold_low) begin
                            report_s = 1'b1;
                            if (dead_time == TIME_ZERO) begin
                                state_s = ARMED;
                            end else begin
                                state_s    = DEAD;
                                dead_cnt_s = dead_time;
                            end
                        end else begin
                            state_s = PULSE;
                        end
                    end else begin
                        state_s = PULSE;
                    end
                end
                DEAD: begin
                    if (s_s) begin
                        dead_cnt_s = dead_cnt_r - TIME_ONE;
                        if (dead_cnt_r == TIME_ONE) begin
                            state_s = ARMED;
                        end else begin
                            state_s = DEAD;
                        end
                    end else begin
                        state_s = DEAD;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, pulse tracking and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            peak_reg_r  <= {width{1'b0}};
            rise_cnt_r  <= TIME_ZERO;
            peak_t_r    <= TIME_ZERO;
            dead_cnt_r  <= TIME_ZERO;
            peak_value  <= {width{1'b0}};
            peak_time   <= TIME_ZERO;
            peak_valid  <= 1'b0;
            busy        <= 1'b0;
            event_count <= {count_width{1'b0}};
        end else begin
            state_r    <= state_s;
            peak_reg_r <= peak_reg_s;
            rise_cnt_r <= rise_cnt_s;
            peak_t_r   <= peak_t_s;
            dead_cnt_r <= dead_cnt_s;
            peak_valid <= report_s;
            busy       <= (state_s == PULSE) || (state_s == DEAD);
            if (report_s) begin
                peak_value  <= peak_reg_s;
                peak_time   <= peak_t_s;
                event_count <= count_inc_s;
            end
        end
    end

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Scoreboard bench for pulse_peak_detector: directed samples push expected
// reports into a queue; a monitor checks each peak_valid against it.
module tb_pulse_peak_detector;

    localparam int W  = 12;
    localparam int TW = 4;
    localparam int CW = 32;

    typedef struct {
        longint value;
        longint ptime;
        longint count;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                sampl_freq;
    logic                enable;
    logic signed [W-1:0] data_in;
    logic signed [W-1:0] th_h;
    logic signed [W-1:0] th_l;
    logic [TW-1:0]       dead_time;
    logic signed [W-1:0] peak_value;
    logic [TW-1:0]       peak_time;
    logic                peak_valid;
    logic                busy;
    logic [CW-1:0]       event_count;

    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;
    exp_t exp_q[$];

    pulse_peak_detector #(.width(W), .time_width(TW), .count_width(CW)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .sampl_freq     (sampl_freq),
        .enable         (enable),
        .data_in        (data_in),
        .threshold_high (th_h),
        .threshold_low  (th_l),
        .dead_time      (dead_time),
        .peak_value     (peak_value),
        .peak_time      (peak_time),
        .peak_valid     (peak_valid),
        .busy           (busy),
        .event_count    (event_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_report(input longint v, input longint t);
        exp_t e;
        exp_count++;
        e.value = v;
        e.ptime = t;
        e.count = exp_count;
        exp_q.push_back(e);
    endtask

    // One sample: a single strobe, three clks per sample.
    task automatic sample(input int v);
        @(negedge clk);
        data_in    = W'(v);
        sampl_freq = 1'b1;
        @(negedge clk);
        sampl_freq = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && peak_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_peak_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("peak_value", longint'(peak_value), e.value);
                check("peak_time", longint'(peak_time), e.ptime);
                check("event_count", longint'(event_count), e.count);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        sampl_freq = 1'b0;
        enable     = 1'b0;
        data_in    = '0;
        th_h       = 12'sd100;
        th_l       = 12'sd50;
        dead_time  = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_peak_value", longint'(peak_value), 0);
        check("rst_peak_time", longint'(peak_time), 0);
        check("rst_peak_valid", longint'(peak_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_event_count", longint'(event_count), 0);
        rst_n  = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);

        // Pulse capture
        sample(0);
        sample(120);
        check("capture_busy_after_trigger", longint'(busy), 1);
        sample(300);
        sample(250);
        expect_report(300, 1);
        sample(40);
        check("capture_busy_after_end", longint'(busy), 0);

        // Hysteresis: 80 and 60 neither end nor retrigger
        sample(120);
        sample(80);
        sample(60);
        sample(200);
        expect_report(200, 3);
        sample(30);

        // Dead time of three samples
        dead_time = 4'd3;
        sample(120);
        expect_report(120, 0);
        sample(40);
        check("dead_busy_end", longint'(busy), 1);
        sample(500);
        check("dead_busy_1", longint'(busy), 1);
        sample(500);
        check("dead_busy_2", longint'(busy), 1);
        sample(500);
        check("dead_busy_3_rearmed", longint'(busy), 0);
        sample(500);
        check("dead_retrigger", longint'(busy), 1);
        expect_report(500, 0);
        sample(40);
        dead_time = 4'd9;
        sample(0);
        sample(0);
        sample(0);
        check("dead_time_latched", longint'(busy), 0);
        dead_time = 4'd0;

        // Enable abort mid-pulse
        sample(120);
        sample(200);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_busy", longint'(busy), 0);
        sample(20);
        check("abort_event_count", longint'(event_count), exp_count);
        check("abort_peak_value_hold", longint'(peak_value), 500);
        enable = 1'b1;
        @(negedge clk);
        sample(120);
        check("reenable_trigger", longint'(busy), 1);
        expect_report(120, 0);
        sample(20);

        // Pulse end and enable fall on the same strobe
        sample(150);
        @(negedge clk);
        data_in    = 12'sd10;
        sampl_freq = 1'b1;
        enable     = 1'b0;
        @(negedge clk);
        sampl_freq = 1'b0;
        @(negedge clk);
        check("same_cycle_busy", longint'(busy), 0);
        check("same_cycle_event_count", longint'(event_count), exp_count);
        enable = 1'b1;
        @(negedge clk);

        // Negative thresholds, equality edges, tied peaks
        th_h = -12'sd10;
        th_l = -12'sd50;
        sample(-10);
        check("neg_trigger_equal", longint'(busy), 1);
        sample(-50);
        check("equal_low_no_end", longint'(busy), 1);
        sample(-5);
        sample(-5);
        expect_report(-5, 2);
        sample(-60);

        // rise_cnt saturation at 15
        th_h = 12'sd100;
        th_l = 12'sd50;
        sample(100);
        for (int i = 1; i <= 19; i++) begin
            sample(100 + i);
        end
        check("sat_still_busy", longint'(busy), 1);
        expect_report(119, 15);
        sample(0);

        // Reset asserted mid-DEAD
        dead_time = 4'd5;
        sample(120);
        expect_report(120, 0);
        sample(0);
        sample(0);
        check("pre_reset_busy", longint'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_peak_value", longint'(peak_value), 0);
        check("async_rst_peak_time", longint'(peak_time), 0);
        check("async_rst_peak_valid", longint'(peak_valid), 0);
        check("async_rst_busy", longint'(busy), 0);
        check("async_rst_event_count", longint'(event_count), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_count = 0;
        dead_time = 4'd0;
        @(negedge clk);
        sample(130);
        expect_report(130, 0);
        sample(40);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
